// File: rtl/booth_multiplier_core_if.sv
// Handshake and data bundle for the sequential Booth multiplier.
// The master drives operands and start; the slave returns the product and ready.
interface booth_multiplier_core_if #(
    parameter int unsigned MUL_WIDTH = 8
);
    logic                     start;
    logic                     sign;
    logic [MUL_WIDTH-1:0]     data_in1;
    logic [MUL_WIDTH-1:0]     data_in2;
    logic [2*MUL_WIDTH-1:0]   data_out;
    logic                     ready;

    modport master (
        output start,
        output sign,
        output data_in1,
        output data_in2,
        input  data_out,
        input  ready
    );

    modport slave (
        input  start,
        input  sign,
        input  data_in1,
        input  data_in2,
        output data_out,
        output ready
    );
endinterface

// File: rtl/booth_multiplier_core.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, MUL_WIDTH+1 steps
// per product. Operands are extended by one bit so signed and unsigned share one datapath.
module booth_multiplier_core #(
    parameter int unsigned MUL_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    booth_multiplier_core_if.slave    bus
);
    localparam int unsigned W  = MUL_WIDTH;
    localparam int unsigned EW = MUL_WIDTH + 1;
    localparam int unsigned CW = $clog2(EW + 1);

    localparam logic [0:0]    StIdle  = 1'b0;
    localparam logic [0:0]    StBusy  = 1'b1;
    localparam logic [CW-1:0] CntInit = CW'(EW);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    logic [0:0]      state_q, state_d;
    logic [EW-1:0]   a_q, a_d;
    logic [EW-1:0]   q_q, q_d;
    logic [EW-1:0]   m_q, m_d;
    logic            qm1_q, qm1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  dout_q, dout_d;

    logic [EW-1:0]   sum;
    logic [EW-1:0]   a_sh;
    logic [EW-1:0]   q_sh;
    logic [EW-1:0]   ext1;
    logic [EW-1:0]   ext2;

    // Operand extension and one Booth add/sub followed by the arithmetic shift.
    always_comb begin
        ext1 = bus.sign ? {bus.data_in1[W-1], bus.data_in1} : {1'b0, bus.data_in1};
        ext2 = bus.sign ? {bus.data_in2[W-1], bus.data_in2} : {1'b0, bus.data_in2};
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        a_sh = {sum[EW-1], sum[EW-1:1]};
        q_sh = {sum[0], q_q[EW-1:1]};
    end

    // Next-state: accept a start while idle, otherwise iterate until the counter expires.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StBusy;
                    m_d     = ext1;
                    q_d     = ext2;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CntInit;
                end
            end
            default: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StIdle;
                    // The extended product is 2*EW bits; only the low 2*W are significant.
                    dout_d  = {a_sh[W-2:0], q_sh, 1'b0} >> 1;
                end
            end
        endcase
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.ready    = (state_q == StIdle);
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_booth_multiplier_core.sv
// Directed bench for booth_multiplier_core at MUL_WIDTH=4.
module tb_booth_multiplier_core;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    booth_multiplier_core_if #(.MUL_WIDTH(W)) bus ();

    booth_multiplier_core #(.MUL_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start, verify hold-during-busy, latency and result.
    task automatic do_mul(input string tag, input logic sgn, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] prev, input logic [7:0] exp);
        int lo;
        @(negedge clk);
        bus.sign = sgn; bus.data_in1 = a; bus.data_in2 = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "_busy"}, {31'd0, bus.ready}, 32'd0);
        check_eq({tag, "_hold"}, {24'd0, bus.data_out}, {24'd0, prev});
        lo = 0;
        while (!bus.ready && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        check_eq({tag, "_lat"}, lo, 32'd5);
        check_eq({tag, "_prod"}, {24'd0, bus.data_out}, {24'd0, exp});
    endtask

    initial begin
        int lo;
        int last;
        int gaps;
        checks = 0;
        failures = 0;
        bus.start = 1'b0; bus.sign = 1'b0; bus.data_in1 = '0; bus.data_in2 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, bus.ready}, 32'd1);
        check_eq("rst_dout", {24'd0, bus.data_out}, 32'd0);

        do_mul("u6x3",   1'b0, 4'd6, 4'd3, 8'h00, 8'h12);
        do_mul("sm6x3",  1'b1, 4'hA, 4'd3, 8'h12, 8'hEE);
        do_mul("sm6xm3", 1'b1, 4'hA, 4'hD, 8'hEE, 8'h12);
        do_mul("sm7xm2", 1'b1, 4'h9, 4'hE, 8'h12, 8'h0E);
        do_mul("u15x15", 1'b0, 4'hF, 4'hF, 8'h0E, 8'hE1);
        do_mul("sm8xm8", 1'b1, 4'h8, 4'h8, 8'hE1, 8'h40);
        do_mul("sm8x7",  1'b1, 4'h8, 4'd7, 8'h40, 8'hC8);
        do_mul("u10x3",  1'b0, 4'hA, 4'd3, 8'hC8, 8'h1E);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        bus.sign = 1'b0; bus.data_in1 = 4'd6; bus.data_in2 = 4'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.sign = 1'b1; bus.data_in1 = 4'h8; bus.data_in2 = 4'h8; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lo = 2;
        while (!bus.ready && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        check_eq("ign_lat", lo, 32'd5);
        check_eq("ign_prod", {24'd0, bus.data_out}, 32'h12);
        @(negedge clk);
        check_eq("ign_idle", {31'd0, bus.ready}, 32'd1);

        // Reset mid-operation aborts immediately.
        bus.sign = 1'b0; bus.data_in1 = 4'd5; bus.data_in2 = 4'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_ready", {31'd0, bus.ready}, 32'd1);
        check_eq("arst_dout", {24'd0, bus.data_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("arst_post", {31'd0, bus.ready}, 32'd1);

        // Start held high: back-to-back products every W+2 cycles.
        bus.sign = 1'b0; bus.data_in1 = 4'd5; bus.data_in2 = 4'd7; bus.start = 1'b1;
        last = 0;
        gaps = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                check_eq("b2b_gap", i - last, 32'd6);
                check_eq("b2b_prod", {24'd0, bus.data_out}, 32'h23);
                last = i;
                gaps++;
            end
        end
        check_eq("b2b_count", gaps, 32'd3);
        bus.start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
